alu_ex_stage: RTL and testbench

Execute-stage arithmetic block of the pipelined MIPS core. It decodes the 2-bit ALU operation class from the main controller together with the instruction funct field into a 3-bit ALU control code. It then performs the selected 32-bit operation, registering result, zero and overflow flags. It also computes the branch target (PC+4 plus word-shifted immediate) combinationally for the EX/MEM pipeline register.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/adder32.sv | 17 +
 rtl/alu_ex_stage.sv | 119 +++++++++++
 tb/tb_alu_ex_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU: control codes, operation classes, R-type functs.
package alu_pkg;

  // 3-bit ALU control codes driven onto alu_ctl
  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_NOR = 3'b100;
  localparam logic [2:0] CTL_SLT = 3'b111;

  // Operation class from the main controller
  localparam logic [1:0] OP2_ADD   = 2'b00;
  localparam logic [1:0] OP2_SUB   = 2'b01;
  localparam logic [1:0] OP2_RTYPE = 2'b10;
  localparam logic [1:0] OP2_OR    = 2'b11;

  // R-type funct field encodings
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/adder32.sv
// Combinational 32-bit adder with carry-in, carry-out and signed-overflow flag.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  // Full add; overflow when both inputs share a sign the sum does not
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    ovf         = (a[31] == b[31]) && (sum[31] != a[31]);
  end

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: ALU control decode, registered 32-bit ALU, combinational branch target.
module alu_ex_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op2,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm_ext,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] branch_target
);

  logic        sub_sel;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        add_ovf;
  logic [31:0] result_p0;
  logic        ovf_p0;
  logic [31:0] result_p1;
  logic        zero_p1;
  logic        ovf_p1;
  logic        br_cout;
  logic        br_ovf;
  logic        unused_bits;

  // Decode operation class and funct into the ALU control code
  always_comb begin
    alu_ctl = CTL_ADD;
    unique case (alu_op2)
      OP2_ADD: alu_ctl = CTL_ADD;
      OP2_SUB: alu_ctl = CTL_SUB;
      OP2_OR:  alu_ctl = CTL_OR;
      default: begin
        case (funct)
          FN_ADD:  alu_ctl = CTL_ADD;
          FN_SUB:  alu_ctl = CTL_SUB;
          FN_AND:  alu_ctl = CTL_AND;
          FN_OR:   alu_ctl = CTL_OR;
          FN_NOR:  alu_ctl = CTL_NOR;
          FN_SLT:  alu_ctl = CTL_SLT;
          default: alu_ctl = CTL_ADD;
        endcase
      end
    endcase
  end

  // SUB and SLT both subtract through the shared adder (a + ~b + 1)
  assign sub_sel = (alu_ctl == CTL_SUB) || (alu_ctl == CTL_SLT);
  assign add_b   = sub_sel ? ~op_b : op_b;

  adder32 u_alu_add (
    .a   (op_a),
    .b   (add_b),
    .cin (sub_sel),
    .sum (add_sum),
    .cout(add_cout),
    .ovf (add_ovf)
  );

  // ---- stage p0: select ALU result and overflow for the current op ----
  // Select next result; SLT uses diff sign XOR overflow so extremes compare correctly
  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    case (alu_ctl)
      CTL_ADD, CTL_SUB: begin
        result_p0 = add_sum;
        ovf_p0    = add_ovf;
      end
      CTL_SLT: result_p0 = {31'd0, add_sum[31] ^ add_ovf};
      CTL_AND: result_p0 = op_a & op_b;
      CTL_OR:  result_p0 = op_a | op_b;
      CTL_NOR: result_p0 = ~(op_a | op_b);
      default: begin
        result_p0 = '0;
        ovf_p0    = 1'b0;
      end
    endcase
  end

  // ---- stage p1: registered result, zero and overflow ----
  // Register outputs; reset clears everything including the in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      zero_p1   <= (result_p0 == 32'd0);
      ovf_p1    <= ovf_p0;
    end
  end

  assign result   = result_p1;
  assign zero     = zero_p1;
  assign overflow = ovf_p1;

  // Branch target: word-shifted immediate added to PC+4, carry discarded
  adder32 u_br_add (
    .a   (pc_plus4),
    .b   ({imm_ext[29:0], 2'b00}),
    .cin (1'b0),
    .sum (branch_target),
    .cout(br_cout),
    .ovf (br_ovf)
  );

  assign unused_bits = ^{add_cout, br_cout, br_ovf, imm_ext[31:30]};

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  alu_op2 = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [31:0] imm_ext = 32'd0;
  logic [2:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] branch_target;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: expected registered outputs
  bit          m_valid = 1'b0;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_ovf;

  alu_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op2      (alu_op2),
    .funct        (funct),
    .op_a         (op_a),
    .op_b         (op_b),
    .pc_plus4     (pc_plus4),
    .imm_ext      (imm_ext),
    .alu_ctl      (alu_ctl),
    .result       (result),
    .zero         (zero),
    .overflow     (overflow),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode table
  function automatic logic [2:0] ref_ctl(input logic [1:0] op2, input logic [5:0] fn);
    if (op2 == 2'b00) return 3'b010;
    if (op2 == 2'b01) return 3'b110;
    if (op2 == 2'b11) return 3'b001;
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference ALU using wide signed arithmetic
  task automatic ref_exec(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 32'd0;
    ovf = 1'b0;
    case (ctl)
      3'b010: begin s = sa + sb; res = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b110: begin s = sa - sb; res = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b100: res = ~(a | b);
      default: ;
    endcase
  endtask

  // Model update on each rising edge from the inputs presented that cycle
  always @(posedge clk) begin
    logic [31:0] r;
    logic        o;
    if (rst) begin
      m_res   <= 32'd0;
      m_zero  <= 1'b0;
      m_ovf   <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      ref_exec(ref_ctl(alu_op2, funct), op_a, op_b, r, o);
      m_res  <= r;
      m_zero <= (r == 32'd0);
      m_ovf  <= o;
    end
  end

  // Compare process: every falling edge, combinational and registered outputs
  always @(negedge clk) begin
    logic [31:0] bt;
    bt = pc_plus4 + imm_ext * 32'd4;
    check("model_alu_ctl", {29'd0, alu_ctl}, {29'd0, ref_ctl(alu_op2, funct)});
    check("model_branch_target", branch_target, bt);
    if (m_valid) begin
      check("model_result", result, m_res);
      check("model_zero", {31'd0, zero}, {31'd0, m_zero});
      check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // One directed op: drive now (just after a rising edge), check ctl mid-cycle, outputs after edge
  task automatic step(input string name, input logic [1:0] op2, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [2:0] e_ctl,
                      input logic [31:0] e_res, input logic e_zero, input logic e_ovf);
    alu_op2 = op2;
    funct   = fn;
    op_a    = a;
    op_b    = b;
    #2;
    check({name, "_ctl"}, {29'd0, alu_ctl}, {29'd0, e_ctl});
    @(posedge clk);
    #1;
    check({name, "_res"}, result, e_res);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, e_zero});
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] fns [6];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    if ($urandom_range(0, 4) == 0) return 6'($urandom);
    return fns[$urandom_range(0, 5)];
  endfunction

  initial begin
    // Reset holds outputs at zero despite valid inputs
    rst = 1'b1; alu_op2 = 2'b00; op_a = 32'd5; op_b = 32'd3;
    @(posedge clk); #1;
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_result", result, 32'd8);
    check("post_rst_zero", {31'd0, zero}, 32'd0);

    step("rsub_eq",  2'b10, 6'b100010, 32'h1234, 32'h1234, 3'b110, 32'd0, 1'b1, 1'b0);
    step("beq_sub",  2'b01, 6'b000000, 32'd7, 32'd9, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0);
    step("add_ovf",  2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1);
    step("sub_ovf",  2'b01, 6'b000000, 32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1);
    step("slt_m1",   2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    step("slt_ext",  2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1, 1'b0, 1'b0);
    step("slt_pos",  2'b10, 6'b101010, 32'd5, 32'hFFFFFFFD, 3'b111, 32'd0, 1'b1, 1'b0);
    step("and",      2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0);
    step("or",       2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0);
    step("nor",      2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 32'h000F000F, 1'b0, 1'b0);
    step("op2_or",   2'b11, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0);
    step("fn_unk",   2'b10, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00E100E0, 1'b0, 1'b0);

    // Branch target is combinational
    pc_plus4 = 32'h00000010; imm_ext = 32'hFFFFFFFE; #1;
    check("bt_neg", branch_target, 32'h00000008);
    imm_ext = 32'h00000003; #1;
    check("bt_pos", branch_target, 32'h0000001C);
    pc_plus4 = 32'hFFFFFFFC; imm_ext = 32'h00000001; #1;
    check("bt_wrap", branch_target, 32'h00000000);

    // Randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 31) == 0);
      alu_op2  = 2'($urandom);
      funct    = pick_funct();
      op_a     = pick_operand();
      op_b     = pick_operand();
      pc_plus4 = $urandom;
      imm_ext  = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
